// File: rtl/ysyx_210247_mem_lsu_stage.sv
// MEM stage: one-slot EXE->MEM register with a req/gnt/rvalid load/store FSM; ALU ops 1 cycle, loads >= 3 cycles; holds while mem_allow_out=0.
// Optional YSYX_210247_MISALIGN_EXC_EN: misaligned accesses skip the data port and raise exc_o/exc_cause_o.
module ysyx_210247_mem_lsu_stage #(
  parameter int XLEN      = 64,
  parameter int ADDR_W    = 64,
  parameter int DST_W     = 5,
  parameter int PAYLOAD_W = 339
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic                                 mem_valid_in,
  output logic                                 mem_allow_in,
  output logic                                 mem_valid_out,
  input  logic                                 mem_allow_out,
  input  logic                                 ld_i,
  input  logic                                 st_i,
  input  logic [1:0]                           size_i,
  input  logic                                 unsigned_i,
  input  logic [ADDR_W-1:0]                    addr_i,
  input  logic [XLEN-1:0]                      st_data_i,
  input  logic                                 wen_i,
  input  logic [DST_W-1:0]                     wdest_i,
  input  logic [XLEN-1:0]                      wdata_i,
  input  logic [PAYLOAD_W-1:0]                 payload_i,
  output logic                                 dmem_req,
  output logic                                 dmem_we,
  output logic [ADDR_W-1:0]                    dmem_addr,
  output logic [XLEN-1:0]                      dmem_wdata,
  output logic [XLEN/8-1:0]                    dmem_wstrb,
  input  logic                                 dmem_gnt,
  input  logic                                 dmem_rvalid,
  input  logic [XLEN-1:0]                      dmem_rdata,
  output logic [PAYLOAD_W+1+DST_W+XLEN-1:0]    mem_to_wb_bus_o,
  output logic [DST_W-1:0]                     MEM_wdest,
  output logic [XLEN-1:0]                      MEM_result,
  output logic                                 MEM_result_vld
`ifdef YSYX_210247_MISALIGN_EXC_EN
  ,
  output logic                                 exc_o,
  output logic [3:0]                           exc_cause_o
`endif
);
  localparam int NB    = XLEN / 8;
  localparam int OFS_W = $clog2(NB);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]           r_state;
  logic                 r_ld;
  logic                 r_st;
  logic [1:0]           r_size;
  logic                 r_uns;
  logic [ADDR_W-1:0]    r_addr;
  logic [XLEN-1:0]      r_st_data;
  logic                 r_wen;
  logic [DST_W-1:0]     r_wdest;
  logic [XLEN-1:0]      r_result;
  logic [PAYLOAD_W-1:0] r_payload;

  logic                 w_slot;
  logic                 w_done;
  logic                 w_req;
  logic                 w_cap;
  logic                 w_mis;
  logic [OFS_W-1:0]     w_ofs;
  logic [3:0]           w_bytes;
  logic [NB-1:0]        w_mask;
  logic [XLEN-1:0]      w_rsh;
  logic [XLEN-1:0]      w_ld_ext;

  assign w_slot = (r_state != IDLE);
  assign w_done = (r_state == DONE);
  assign w_req  = (r_state == REQ);

  assign mem_valid_out = w_done;
  assign mem_allow_in  = !w_slot || (w_done && mem_allow_out);
  assign w_cap         = mem_valid_in && mem_allow_in;

`ifdef YSYX_210247_MISALIGN_EXC_EN
  logic [OFS_W-1:0] w_in_align;
  logic             r_exc;
  logic [3:0]       r_cause;

  assign w_in_align = OFS_W'((4'd1 << size_i) - 4'd1);
  assign w_mis      = (ld_i || st_i) && ((addr_i[OFS_W-1:0] & w_in_align) != '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_exc   <= 1'b0;
      r_cause <= 4'd0;
    end else if (w_cap) begin
      r_exc   <= w_mis;
      r_cause <= w_mis ? (ld_i ? 4'd4 : 4'd6) : 4'd0;
    end
  end

  assign exc_o       = w_slot && r_exc;
  assign exc_cause_o = w_slot ? r_cause : 4'd0;
`else
  assign w_mis = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_ld      <= 1'b0;
      r_st      <= 1'b0;
      r_size    <= 2'd0;
      r_uns     <= 1'b0;
      r_addr    <= '0;
      r_st_data <= '0;
      r_wen     <= 1'b0;
      r_wdest   <= '0;
      r_result  <= '0;
      r_payload <= '0;
    end else if (w_cap) begin
      r_ld      <= ld_i;
      r_st      <= st_i;
      r_size    <= size_i;
      r_uns     <= unsigned_i;
      r_addr    <= addr_i;
      r_st_data <= st_data_i;
      r_wen     <= wen_i && !st_i && !w_mis;
      r_wdest   <= wdest_i;
      r_result  <= wdata_i;
      r_payload <= payload_i;
      r_state   <= ((ld_i || st_i) && !w_mis) ? REQ : DONE;
    end else begin
      case (r_state)
        REQ:  if (dmem_gnt) r_state <= r_st ? DONE : WAIT;
        WAIT: if (dmem_rvalid) begin
                r_result <= w_ld_ext;
                r_state  <= DONE;
              end
        DONE: if (mem_allow_out) r_state <= IDLE;
        default: ;
      endcase
    end
  end

  // Byte-lane alignment; strobe bits pushed past the top of the field fall off.
  assign w_ofs   = r_addr[OFS_W-1:0];
  assign w_bytes = 4'd1 << r_size;
  assign w_mask  = (NB'(1) << w_bytes) - NB'(1);
  assign w_rsh   = dmem_rdata >> {w_ofs, 3'b000};

  always_comb begin
    w_ld_ext = w_rsh;
    case (r_size)
      2'd0: w_ld_ext = r_uns ? XLEN'(w_rsh[7:0])  : XLEN'($signed(w_rsh[7:0]));
      2'd1: w_ld_ext = r_uns ? XLEN'(w_rsh[15:0]) : XLEN'($signed(w_rsh[15:0]));
      2'd2: w_ld_ext = r_uns ? XLEN'(w_rsh[31:0]) : XLEN'($signed(w_rsh[31:0]));
      default: w_ld_ext = w_rsh;
    endcase
  end

  assign dmem_req   = w_req;
  assign dmem_we    = w_req && r_st;
  assign dmem_addr  = w_req ? {r_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}} : '0;
  assign dmem_wdata = (w_req && r_st) ? (r_st_data << {w_ofs, 3'b000}) : '0;
  assign dmem_wstrb = (w_req && r_st) ? (w_mask << w_ofs) : '0;

  assign mem_to_wb_bus_o = {r_payload, r_wen, r_wdest, r_result};
  assign MEM_wdest       = w_slot ? r_wdest : '0;
  assign MEM_result      = r_result;
  assign MEM_result_vld  = w_slot && !(r_ld && !w_done);

endmodule

// File: tb/tb_ysyx_210247_mem_lsu_stage.sv
// Directed bench for ysyx_210247_mem_lsu_stage: vector table for load/store lane handling plus hand-written handshake sequences.
module tb_ysyx_210247_mem_lsu_stage;
  localparam int XLEN = 64, ADDR_W = 64, DST_W = 5, PAYLOAD_W = 339;
  localparam int BUS_W = PAYLOAD_W + 1 + DST_W + XLEN;
  localparam int WEN_B = XLEN + DST_W;

  logic clock = 1'b0, reset_n = 1'b0;
  logic mem_valid_in, mem_allow_in, mem_valid_out, mem_allow_out;
  logic ld_i, st_i, unsigned_i, wen_i;
  logic [1:0] size_i;
  logic [ADDR_W-1:0] addr_i;
  logic [XLEN-1:0] st_data_i, wdata_i, dmem_wdata, dmem_rdata, MEM_result;
  logic [DST_W-1:0] wdest_i, MEM_wdest;
  logic [PAYLOAD_W-1:0] payload_i;
  logic dmem_req, dmem_we, dmem_gnt, dmem_rvalid, MEM_result_vld;
  logic [ADDR_W-1:0] dmem_addr;
  logic [XLEN/8-1:0] dmem_wstrb;
  logic [BUS_W-1:0] bus;
`ifdef YSYX_210247_MISALIGN_EXC_EN
  logic exc_o;
  logic [3:0] exc_cause_o;
`endif

  ysyx_210247_mem_lsu_stage dut (
    .clock(clock), .reset_n(reset_n),
    .mem_valid_in(mem_valid_in), .mem_allow_in(mem_allow_in),
    .mem_valid_out(mem_valid_out), .mem_allow_out(mem_allow_out),
    .ld_i(ld_i), .st_i(st_i), .size_i(size_i), .unsigned_i(unsigned_i),
    .addr_i(addr_i), .st_data_i(st_data_i), .wen_i(wen_i), .wdest_i(wdest_i),
    .wdata_i(wdata_i), .payload_i(payload_i),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .mem_to_wb_bus_o(bus), .MEM_wdest(MEM_wdest), .MEM_result(MEM_result),
    .MEM_result_vld(MEM_result_vld)
`ifdef YSYX_210247_MISALIGN_EXC_EN
    , .exc_o(exc_o), .exc_cause_o(exc_cause_o)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        ld;
    logic        st;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] st_data;
    logic [63:0] rdata;
    logic [63:0] exp_data;   // expected dmem_wdata for stores, MEM_result for loads
    logic [7:0]  exp_strb;
  } vec_t;

  vec_t vecs[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_valid_in = 1'b0; ld_i = 1'b0; st_i = 1'b0; size_i = 2'd0; unsigned_i = 1'b0;
    addr_i = '0; st_data_i = '0; wen_i = 1'b0; wdest_i = '0; wdata_i = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
  endtask

  task automatic add_vec(input logic ld, input logic st, input logic [1:0] size, input logic uns,
                         input logic [63:0] addr, input logic [63:0] sd, input logic [63:0] rd,
                         input logic [63:0] exp, input logic [7:0] strb);
    vec_t v;
    v.ld = ld; v.st = st; v.size = size; v.uns = uns; v.addr = addr;
    v.st_data = sd; v.rdata = rd; v.exp_data = exp; v.exp_strb = strb;
    vecs.push_back(v);
  endtask

  // Issue one memory op at a negedge, grant immediately, return rvalid the cycle after gnt.
  task automatic run_vec(input vec_t v, input int idx);
    mem_valid_in = 1'b1; ld_i = v.ld; st_i = v.st; size_i = v.size; unsigned_i = v.uns;
    addr_i = v.addr; st_data_i = v.st_data; wen_i = 1'b1; wdest_i = 5'd9; wdata_i = 64'h1111;
    mem_allow_out = 1'b1;
    @(posedge clock); @(negedge clock);
    mem_valid_in = 1'b0;
    check($sformatf("v%0d_req", idx), 64'(dmem_req), 64'd1);
    check($sformatf("v%0d_we", idx), 64'(dmem_we), 64'(v.st));
    check($sformatf("v%0d_addr", idx), dmem_addr, v.addr & ~64'h7);
    if (v.st) begin
      check($sformatf("v%0d_wstrb", idx), 64'(dmem_wstrb), 64'(v.exp_strb));
      check($sformatf("v%0d_wdata", idx), dmem_wdata, v.exp_data);
    end
    dmem_gnt = 1'b1;
    @(posedge clock); @(negedge clock);
    dmem_gnt = 1'b0;
    if (v.ld) begin
      check($sformatf("v%0d_wait_vout", idx), 64'(mem_valid_out), 64'd0);
      check($sformatf("v%0d_wait_rvld", idx), 64'(MEM_result_vld), 64'd0);
      dmem_rvalid = 1'b1; dmem_rdata = v.rdata;
      @(posedge clock); @(negedge clock);
      dmem_rvalid = 1'b0;
      check($sformatf("v%0d_result", idx), MEM_result, v.exp_data);
    end
    check($sformatf("v%0d_vout", idx), 64'(mem_valid_out), 64'd1);
    check($sformatf("v%0d_bus_wen", idx), 64'(bus[WEN_B]), 64'(v.ld));
    @(posedge clock); @(negedge clock);
    check($sformatf("v%0d_drained", idx), 64'(mem_valid_out), 64'd0);
  endtask

  initial begin
    int xfers;
    idle_inputs();
    mem_allow_out = 1'b1;
    payload_i = PAYLOAD_W'({6{64'hDEADBEEF_0BADF00D}});

    add_vec(1, 0, 2'd0, 0, 64'h0000_0000_0000_1003, '0, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80, 8'h00);
    add_vec(1, 0, 2'd0, 1, 64'h0000_0000_0000_1003, '0, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080, 8'h00);
    add_vec(0, 1, 2'd1, 0, 64'h0000_0000_0000_2006, 64'hBEEF, '0, 64'hBEEF_0000_0000_0000, 8'hC0);
    add_vec(1, 0, 2'd2, 0, 64'h0000_0000_0000_3004, '0, 64'h8765_4321_1234_5678, 64'hFFFF_FFFF_8765_4321, 8'h00);
    add_vec(1, 0, 2'd2, 1, 64'h0000_0000_0000_3004, '0, 64'h8765_4321_1234_5678, 64'h0000_0000_8765_4321, 8'h00);
    add_vec(1, 0, 2'd1, 0, 64'h0000_0000_0000_4002, '0, 64'h0000_0000_7FFF_0000, 64'h0000_0000_0000_7FFF, 8'h00);
    add_vec(1, 0, 2'd3, 0, 64'h0000_0000_0000_5000, '0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 8'h00);
    add_vec(0, 1, 2'd0, 0, 64'h0000_0000_0000_6007, 64'hAA, '0, 64'hAA00_0000_0000_0000, 8'h80);
    add_vec(0, 1, 2'd3, 0, 64'h0000_0000_0000_7000, 64'h1122_3344_5566_7788, '0, 64'h1122_3344_5566_7788, 8'hFF);
    add_vec(0, 1, 2'd2, 0, 64'h0000_0000_0000_8004, 64'hCAFE_BABE, '0, 64'hCAFE_BABE_0000_0000, 8'hF0);
`ifndef YSYX_210247_MISALIGN_EXC_EN
    add_vec(0, 1, 2'd2, 0, 64'h0000_0000_0000_9006, 64'hCAFE_BABE, '0, 64'hBABE_0000_0000_0000, 8'hC0);
`endif

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_vout_in_reset", 64'(mem_valid_out), 64'd0);
    reset_n = 1'b1;
    @(negedge clock);
    check("rst_vout", 64'(mem_valid_out), 64'd0);
    check("rst_allow_in", 64'(mem_allow_in), 64'd1);
    check("rst_req", 64'(dmem_req), 64'd0);
    check("rst_wdest", 64'(MEM_wdest), 64'd0);
    check("rst_rvld", 64'(MEM_result_vld), 64'd0);
    check("rst_bus_nonzero", 64'(|bus), 64'd0);

    // Back-to-back ALU ops
    for (int i = 0; i < 3; i++) begin
      mem_valid_in = 1'b1; wen_i = 1'b1; wdest_i = DST_W'(5 + i); wdata_i = 64'(100 + i);
      @(posedge clock); @(negedge clock);
      check($sformatf("alu%0d_vout", i), 64'(mem_valid_out), 64'd1);
      check($sformatf("alu%0d_wdest", i), 64'(MEM_wdest), 64'(5 + i));
      check($sformatf("alu%0d_result", i), bus[XLEN-1:0], 64'(100 + i));
      check($sformatf("alu%0d_allow_in", i), 64'(mem_allow_in), 64'd1);
    end
    check("alu_bus_wen", 64'(bus[WEN_B]), 64'd1);
    check("alu_payload", bus[WEN_B+64:WEN_B+1], 64'hDEADBEEF_0BADF00D);
    check("alu_req", 64'(dmem_req), 64'd0);
    idle_inputs();
    @(posedge clock); @(negedge clock);
    check("alu_end_vout", 64'(mem_valid_out), 64'd0);
    check("alu_end_wdest", 64'(MEM_wdest), 64'd0);

    foreach (vecs[i]) begin
      run_vec(vecs[i], i);
      idle_inputs();
    end

    // Backpressure: gnt held off 4 cycles, then WB stalls 3 cycles
    mem_valid_in = 1'b1; st_i = 1'b1; size_i = 2'd3; addr_i = 64'h8000_0000_0000_0010;
    st_data_i = 64'h0123_4567_89AB_CDEF; wen_i = 1'b1; wdest_i = 5'd3; wdata_i = 64'h55;
    mem_allow_out = 1'b0;
    @(posedge clock); @(negedge clock);
    mem_valid_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp_req_%0d", i), 64'(dmem_req), 64'd1);
      check($sformatf("bp_addr_%0d", i), dmem_addr, 64'h8000_0000_0000_0010);
      check($sformatf("bp_wdata_%0d", i), dmem_wdata, 64'h0123_4567_89AB_CDEF);
      check($sformatf("bp_wstrb_%0d", i), 64'(dmem_wstrb), 64'hFF);
      check($sformatf("bp_allow_in_%0d", i), 64'(mem_allow_in), 64'd0);
      check($sformatf("bp_vout_%0d", i), 64'(mem_valid_out), 64'd0);
      @(posedge clock); @(negedge clock);
    end
    dmem_gnt = 1'b1;
    @(posedge clock); @(negedge clock);
    dmem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_hold_vout_%0d", i), 64'(mem_valid_out), 64'd1);
      check($sformatf("bp_hold_allow_in_%0d", i), 64'(mem_allow_in), 64'd0);
      check($sformatf("bp_hold_req_%0d", i), 64'(dmem_req), 64'd0);
      check($sformatf("bp_hold_wdest_%0d", i), 64'(MEM_wdest), 64'd3);
      check($sformatf("bp_hold_wen_%0d", i), 64'(bus[WEN_B]), 64'd0);
      @(posedge clock); @(negedge clock);
    end
    mem_allow_out = 1'b1;
    xfers = 0;
    for (int i = 0; i < 4; i++) begin
      if (mem_valid_out && mem_allow_out) xfers++;
      @(posedge clock); @(negedge clock);
    end
    check("bp_xfers", 64'(xfers), 64'd1);
    idle_inputs();

    // Reset while waiting on rvalid; a later rvalid must be ignored
    mem_valid_in = 1'b1; ld_i = 1'b1; size_i = 2'd0; addr_i = 64'h3; wen_i = 1'b1; wdest_i = 5'd12;
    @(posedge clock); @(negedge clock);
    mem_valid_in = 1'b0; dmem_gnt = 1'b1;
    @(posedge clock); @(negedge clock);
    dmem_gnt = 1'b0;
    check("rw_pre_rvld", 64'(MEM_result_vld), 64'd0);
    reset_n = 1'b0;
    #1;
    check("rw_async_vout", 64'(mem_valid_out), 64'd0);
    check("rw_async_allow_in", 64'(mem_allow_in), 64'd1);
    @(posedge clock); @(negedge clock);
    reset_n = 1'b1;
    dmem_rvalid = 1'b1; dmem_rdata = 64'h0000_0000_8000_0000;
    @(posedge clock); @(negedge clock);
    dmem_rvalid = 1'b0;
    check("rw_vout", 64'(mem_valid_out), 64'd0);
    check("rw_rvld", 64'(MEM_result_vld), 64'd0);
    check("rw_allow_in", 64'(mem_allow_in), 64'd1);
    check("rw_result", MEM_result, 64'd0);
    check("rw_wdest", 64'(MEM_wdest), 64'd0);
    @(posedge clock); @(negedge clock);
    check("rw_vout_later", 64'(mem_valid_out), 64'd0);
    idle_inputs();

`ifdef YSYX_210247_MISALIGN_EXC_EN
    mem_valid_in = 1'b1; ld_i = 1'b1; size_i = 2'd2; addr_i = 64'h0000_0000_0000_0102; wen_i = 1'b1;
    @(posedge clock); @(negedge clock);
    mem_valid_in = 1'b0;
    check("mis_req", 64'(dmem_req), 64'd0);
    check("mis_vout", 64'(mem_valid_out), 64'd1);
    check("mis_exc", 64'(exc_o), 64'd1);
    check("mis_cause", 64'(exc_cause_o), 64'd4);
    check("mis_wen", 64'(bus[WEN_B]), 64'd0);
    @(posedge clock); @(negedge clock);
    idle_inputs();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
